ecc_apb_cmd_master: RTL and testbench

//  Upstream neighbour of the ECC encoder/decoder: turns a simple valid/ready register-command

---
 rtl/ecc_apb_pkg.sv | 26 ++
 rtl/ecc_cmd_fifo.sv | 46 ++++
 rtl/ecc_apb_cmd_master.sv | 132 +++++++++++++
 tb/tb_ecc_apb_cmd_master.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_apb_pkg.sv
// rtl/ecc_apb_pkg.sv - shared types and register map for the ECC APB command master
package ecc_apb_pkg;

  localparam int CMD_ADDR_W = 20;
  localparam int CMD_WORD_W = 32;

  localparam logic [CMD_ADDR_W-1:0] REG_CTRL           = 20'h00;
  localparam logic [CMD_ADDR_W-1:0] REG_DATA_IN        = 20'h04;
  localparam logic [CMD_ADDR_W-1:0] REG_CODEWORD_WIDTH = 20'h08;
  localparam logic [CMD_ADDR_W-1:0] REG_NOISE          = 20'h0C;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETUP     = 3'd1,
    ST_ACCESS    = 3'd2,
    ST_RB_SETUP  = 3'd3,
    ST_RB_ACCESS = 3'd4
  } apb_state_t;

  typedef struct packed {
    logic                  write;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_WORD_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/ecc_cmd_fifo.sv
// rtl/ecc_cmd_fifo.sv - synchronous command FIFO with extra-MSB pointers for full/empty
module ecc_cmd_fifo
  import ecc_apb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  cmd_t push_data,
  input  logic pop,
  output cmd_t head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  cmd_t          mem [DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage needs no reset: pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ecc_apb_cmd_master.sv
// rtl/ecc_apb_cmd_master.sv - command FIFO to APB master; ECC_APB_RDBK_VERIFY_EN adds write readback check
module ecc_apb_cmd_master
  import ecc_apb_pkg::*;
#(
  parameter int AMBA_ADDR_WIDTH = CMD_ADDR_W,
  parameter int AMBA_WORD       = CMD_WORD_W,
  parameter int CMD_DEPTH       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [AMBA_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [AMBA_WORD-1:0]       cmd_wdata,
  output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  output logic [AMBA_WORD-1:0]       PWDATA,
  output logic                       PWRITE,
  output logic                       PSEL,
  output logic                       PENABLE,
  input  logic [AMBA_WORD-1:0]       PRDATA,
  output logic                       rsp_valid,
  output logic [AMBA_WORD-1:0]       rsp_rdata,
  output logic                       busy,
  output logic                       rdbk_err
);

  apb_state_t state;
  cmd_t       push_cmd;
  cmd_t       head_cmd;
  logic       fifo_full;
  logic       fifo_empty;
  logic       xfer_done;
  logic       pop;

  assign cmd_ready = !fifo_full;
  assign push_cmd  = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
  assign busy      = !fifo_empty || (state != ST_IDLE);

  ecc_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cmd_valid && cmd_ready),
    .push_data (push_cmd),
    .pop       (pop),
    .head      (head_cmd),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // A transfer is finished once no readback remains owed for it.
  always_comb begin
`ifdef ECC_APB_RDBK_VERIFY_EN
    xfer_done = ((state == ST_ACCESS) && !PWRITE) || (state == ST_RB_ACCESS);
`else
    xfer_done = (state == ST_ACCESS);
`endif
  end

  assign pop = !fifo_empty && ((state == ST_IDLE) || xfer_done);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (pop) begin
        state   <= ST_SETUP;
        PSEL    <= 1'b1;
        PENABLE <= 1'b0;
        PWRITE  <= head_cmd.write;
        PADDR   <= head_cmd.addr;
        PWDATA  <= head_cmd.wdata;
      end else begin
        case (state)
          ST_SETUP: begin
            state   <= ST_ACCESS;
            PENABLE <= 1'b1;
          end
          ST_ACCESS: begin
`ifdef ECC_APB_RDBK_VERIFY_EN
            if (PWRITE) begin
              state   <= ST_RB_SETUP;
              PWRITE  <= 1'b0;
              PENABLE <= 1'b0;
            end else
`endif
            begin
              state   <= ST_IDLE;
              PSEL    <= 1'b0;
              PENABLE <= 1'b0;
            end
          end
`ifdef ECC_APB_RDBK_VERIFY_EN
          ST_RB_SETUP: begin
            state   <= ST_RB_ACCESS;
            PENABLE <= 1'b1;
          end
          ST_RB_ACCESS: begin
            state   <= ST_IDLE;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
          end
`endif
          default: ;
        endcase
      end
      if ((state == ST_ACCESS) && !PWRITE) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= PRDATA;
      end
    end
  end

`ifdef ECC_APB_RDBK_VERIFY_EN
  // PWDATA still holds the written value throughout the readback.
  always_ff @(posedge clk) begin
    if (rst) rdbk_err <= 1'b0;
    else     rdbk_err <= (state == ST_RB_ACCESS) && (PRDATA != PWDATA);
  end
`else
  assign rdbk_err = 1'b0;
`endif

endmodule

// File: tb/tb_ecc_apb_cmd_master.sv
// tb/tb_ecc_apb_cmd_master.sv - self-checking bench for ecc_apb_cmd_master
module tb_ecc_apb_cmd_master;
  import ecc_apb_pkg::*;

  localparam int CMD_DEPTH = 4;
`ifdef ECC_APB_RDBK_VERIFY_EN
  localparam bit WR_PSEL3 = 1'b1;
`else
  localparam bit WR_PSEL3 = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [19:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [19:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE, PSEL, PENABLE;
  logic [31:0] PRDATA;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        busy, rdbk_err;

  logic        ovr_en = 1'b0;
  logic [31:0] ovr_val = '0;
  logic [31:0] smem [16];
  logic [31:0] mmem [16];

  assign PRDATA = ovr_en ? ovr_val : smem[PADDR[5:2]];

  always #5 clk = ~clk;

  ecc_apb_cmd_master #(.AMBA_ADDR_WIDTH(20), .AMBA_WORD(32), .CMD_DEPTH(CMD_DEPTH)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .busy(busy), .rdbk_err(rdbk_err)
  );

  typedef struct {
    bit          write;
    logic [19:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    bit          exp_rsp;
    logic [31:0] exp_rdata;
    bit          exp_psel3;
  } vec_t;

  typedef struct {
    bit          write;
    logic [19:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t cur;
  int   pushes, pops, pend_before, last_push;
  bit   mon_en, rsp_due, in_rb, saw_full;
  bit   prev_psel, prev_pen, prev_pwrite;
  logic [31:0] rsp_exp;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic init_mem();
    for (int i = 0; i < 16; i++) begin
      smem[i] = (i * 32'h0101_0101) ^ 32'hC0DE_0000;
      mmem[i] = (i * 32'h0101_0101) ^ 32'hC0DE_0000;
    end
  endtask

  // Transaction-level model: commands leave in acceptance order, reads see all earlier writes.
  task automatic model_accept();
    exp_t e;
    e.write = cmd_write;
    e.addr  = cmd_addr;
    e.wdata = cmd_wdata;
    e.rdata = cmd_write ? 32'h0 : mmem[cmd_addr[5:2]];
    if (cmd_write) mmem[cmd_addr[5:2]] = cmd_wdata;
    exp_q.push_back(e);
    pushes++;
  endtask

  task automatic monitor();
    bit was_acc;
    was_acc = prev_psel && prev_pen;
    chk("rsp_valid", rsp_valid, rsp_due);
    if (rsp_due && rsp_valid) chk("rsp_rdata", rsp_rdata, rsp_exp);
    rsp_due = 1'b0;
    chk("rdbk_err", rdbk_err, 0);
`ifdef ECC_APB_RDBK_VERIFY_EN
    if (was_acc && prev_pwrite) begin
      chk("rb_psel", PSEL, 1);
      chk("rb_penable", PENABLE, 0);
      chk("rb_pwrite", PWRITE, 0);
      chk("rb_paddr", PADDR, cur.addr);
      in_rb = 1'b1;
    end else
`endif
    if (!prev_psel || was_acc) begin
      chk("psel_issue", PSEL, pend_before > 0);
      chk("penable_setup", PENABLE, 0);
      if (PSEL && exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        pops++;
        in_rb = 1'b0;
        chk("paddr", PADDR, cur.addr);
        chk("pwrite", PWRITE, cur.write);
        if (cur.write) chk("pwdata", PWDATA, cur.wdata);
      end
    end else begin
      chk("psel_access", PSEL, 1);
      chk("penable_access", PENABLE, 1);
      chk("paddr_hold", PADDR, cur.addr);
      chk("pwrite_hold", PWRITE, in_rb ? 1'b0 : cur.write);
      if (!in_rb && !PWRITE) begin
        rsp_due = 1'b1;
        rsp_exp = cur.rdata;
      end
    end
    chk("cmd_ready", cmd_ready, (pushes - pops) < CMD_DEPTH);
    prev_psel   = PSEL;
    prev_pen    = PENABLE;
    prev_pwrite = PWRITE;
  endtask

  task automatic step();
    bit acc;
    acc = cmd_valid && cmd_ready;
    pend_before = exp_q.size();
    @(posedge clk);
    #1;
    if (PSEL && PENABLE && PWRITE) smem[PADDR[5:2]] = PWDATA;
    if (mon_en) begin
      if (acc) model_accept();
      monitor();
    end
  endtask

  task automatic reset_dut();
    mon_en = 1'b0;
    cmd_valid = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    exp_q.delete();
    pushes = 0; pops = 0; rsp_due = 0; in_rb = 0;
    prev_psel = 0; prev_pen = 0; prev_pwrite = 0;
  endtask

  task automatic drain(input string name);
    cmd_valid = 1'b0;
    for (int i = 0; i < 40 && (busy || rsp_due); i++) step();
    step();
    chk(name, busy, 0);
  endtask

  initial begin
    vecs[0] = '{write: 1'b1, addr: REG_DATA_IN,        wdata: 32'hDEADBEEF, prdata: 32'h0,
                exp_rsp: 1'b0, exp_rdata: 32'h0,        exp_psel3: WR_PSEL3};
    vecs[1] = '{write: 1'b0, addr: REG_CODEWORD_WIDTH, wdata: 32'h1111_2222, prdata: 32'h0000_0002,
                exp_rsp: 1'b1, exp_rdata: 32'h0000_0002, exp_psel3: 1'b0};
    vecs[2] = '{write: 1'b1, addr: REG_CTRL,           wdata: 32'h0000_0001, prdata: 32'h0,
                exp_rsp: 1'b0, exp_rdata: 32'h0,        exp_psel3: WR_PSEL3};
    vecs[3] = '{write: 1'b0, addr: REG_NOISE,          wdata: 32'h0,         prdata: 32'hFFFF_FFFF,
                exp_rsp: 1'b1, exp_rdata: 32'hFFFF_FFFF, exp_psel3: 1'b0};
    vecs[4] = '{write: 1'b0, addr: REG_CTRL,           wdata: 32'hA5A5_A5A5, prdata: 32'h0,
                exp_rsp: 1'b1, exp_rdata: 32'h0,        exp_psel3: 1'b0};

    init_mem();
    reset_dut();
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdbk_err", rdbk_err, 0);
    chk("rst_cmd_ready", cmd_ready, 1);

    // Single isolated commands: SETUP at T+1, ACCESS at T+2, response at T+3.
    for (int v = 0; v < 5; v++) begin
      ovr_en    = !vecs[v].write;
      ovr_val   = vecs[v].prdata;
      cmd_valid = 1'b1;
      cmd_write = vecs[v].write;
      cmd_addr  = vecs[v].addr;
      cmd_wdata = vecs[v].wdata;
      step();
      cmd_valid = 1'b0;
      chk("t0_psel", PSEL, 0);
      step();
      chk("t1_psel", PSEL, 1);
      chk("t1_penable", PENABLE, 0);
      chk("t1_paddr", PADDR, vecs[v].addr);
      chk("t1_pwrite", PWRITE, vecs[v].write);
      step();
      chk("t2_psel", PSEL, 1);
      chk("t2_penable", PENABLE, 1);
      if (vecs[v].write) chk("t2_pwdata", PWDATA, vecs[v].wdata);
      step();
      chk("t3_rsp_valid", rsp_valid, vecs[v].exp_rsp);
      if (vecs[v].exp_rsp) chk("t3_rsp_rdata", rsp_rdata, vecs[v].exp_rdata);
      chk("t3_psel", PSEL, vecs[v].exp_psel3);
      chk("t3_rdbk_err", rdbk_err, 0);
      step();
      chk("t4_rsp_valid", rsp_valid, 0);
      drain("vec_idle");
    end
    ovr_en = 1'b0;

`ifdef ECC_APB_RDBK_VERIFY_EN
    // Write 0x0C=0x5 while the slave answers 0x4: readback follows and flags the mismatch.
    ovr_en = 1'b1;
    ovr_val = 32'h4;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = REG_NOISE; cmd_wdata = 32'h5;
    step();
    cmd_valid = 1'b0;
    step();
    chk("rb_w_setup", {PSEL, PENABLE, PWRITE}, 3'b101);
    step();
    chk("rb_w_access", {PSEL, PENABLE, PWRITE}, 3'b111);
    step();
    chk("rb_r_setup", {PSEL, PENABLE, PWRITE}, 3'b100);
    chk("rb_r_paddr", PADDR, REG_NOISE);
    chk("rb_r_rsp", rsp_valid, 0);
    step();
    chk("rb_r_access", {PSEL, PENABLE, PWRITE}, 3'b110);
    chk("rb_err_early", rdbk_err, 0);
    step();
    chk("rb_err_pulse", rdbk_err, 1);
    chk("rb_no_rsp", rsp_valid, 0);
    chk("rb_idle", PSEL, 0);
    step();
    chk("rb_err_once", rdbk_err, 0);
    chk("rb_no_rsp2", rsp_valid, 0);
    ovr_en = 1'b0;
    drain("rb_idle_end");
`endif

    // Reset while a read is in its ACCESS phase.
    reset_dut();
    ovr_en = 1'b1;
    ovr_val = 32'h1234_5678;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = REG_CODEWORD_WIDTH;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    chk("abort_in_access", PENABLE, 1);
    rst = 1'b1;
    step();
    chk("abort_psel", PSEL, 0);
    chk("abort_penable", PENABLE, 0);
    chk("abort_rsp", rsp_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", cmd_ready, 1);
    rst = 1'b0;
    step();
    chk("abort_rsp_after", rsp_valid, 0);
    chk("abort_rdata", rsp_rdata, 0);
    chk("abort_busy_after", busy, 0);
    ovr_en = 1'b0;

    // Back-to-back burst with cmd_valid held: fills the FIFO and back-pressures.
    reset_dut();
    init_mem();
    mon_en = 1'b1;
    saw_full = 1'b0;
    last_push = -1;
    for (int cyc = 0; cyc < 80 && pushes < 10; cyc++) begin
      if (pushes != last_push) begin
        last_push = pushes;
        cmd_write = $urandom_range(0, 1);
        cmd_addr  = 20'($urandom_range(0, 15) * 4);
        cmd_wdata = $urandom;
      end
      cmd_valid = 1'b1;
      if (!cmd_ready) saw_full = 1'b1;
      step();
    end
    drain("burst_idle");
    chk("burst_saw_full", saw_full, 1);
    chk("burst_count", pushes, 10);
    chk("burst_q_empty", exp_q.size(), 0);

    // Random traffic against the transaction-level model.
    for (int cyc = 0; cyc < 400; cyc++) begin
      cmd_valid = ($urandom_range(0, 9) < 6);
      cmd_write = $urandom_range(0, 1);
      cmd_addr  = 20'($urandom_range(0, 15) * 4);
      cmd_wdata = $urandom;
      step();
    end
    drain("rand_idle");
    chk("rand_q_empty", exp_q.size(), 0);
    chk("rand_balance", pops, pushes);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
